// File: rtl/alarm_sequencer.sv
// -----------------------------------------------------------------------------
// alarm_sequencer
//
// Turns the comparator's level-type `match` (high for the whole matching
// minute) into a bounded alarm ring with snooze and dismiss handling. Clocked
// by the one-per-second Pulse, so every counter below counts seconds.
//
// Parameters:
//   RING_SECS   (1..127)  ring length before auto-timeout
//   SNOOZE_SECS (1..1023) snooze interval length
//   MAX_SNOOZE  (0..7)    snoozes allowed per alarm event
//
// Ports:
//   Pulse      in   clock, one cycle per second
//   Reset      in   synchronous, active-high reset
//   alarmOn    in   alarm enable; low forces the block idle
//   match      in   time equals alarm time (level)
//   snooze     in   snooze request (level-sampled)
//   dismiss    in   dismiss request (level-sampled)
//   buzz       out  alarm sounding
//   snoozing   out  snooze interval in progress
//   missed     out  sticky: last ring timed out unanswered
//   snooze_num out  snoozes used in the current alarm event
// -----------------------------------------------------------------------------
module alarm_sequencer #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 540,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic       Pulse,
    input  logic       Reset,
    input  logic       alarmOn,
    input  logic       match,
    input  logic       snooze,
    input  logic       dismiss,
    output logic       buzz,
    output logic       snoozing,
    output logic       missed,
    output logic [2:0] snooze_num
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RINGING = 2'd1;
    localparam logic [1:0] ST_SNOOZE  = 2'd2;

    localparam logic [6:0] RING_LOAD   = 7'(RING_SECS - 1);
    localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_SECS - 1);
    localparam logic [2:0] SNOOZE_MAX  = 3'(MAX_SNOOZE);

    logic [1:0] state_q, state_d;
    logic       match_q;
    logic [6:0] ring_cnt_q, ring_cnt_d;
    logic [9:0] snz_cnt_q, snz_cnt_d;
    logic [2:0] snooze_num_q, snooze_num_d;
    logic       missed_q, missed_d;
    logic       rise;

    // Snooze count saturates at the configured limit.
    function automatic logic [2:0] snooze_sat_inc(input logic [2:0] n);
        return (n < SNOOZE_MAX) ? n + 3'd1 : SNOOZE_MAX;
    endfunction

    // Only the rising edge of match starts an alarm, so a dismissed alarm
    // stays quiet for the rest of the matching minute.
    assign rise = match & ~match_q;

    always_comb begin
        state_d      = state_q;
        ring_cnt_d   = ring_cnt_q;
        snz_cnt_d    = snz_cnt_q;
        snooze_num_d = snooze_num_q;
        missed_d     = missed_q;

        if (!alarmOn) begin
            state_d      = ST_IDLE;
            ring_cnt_d   = '0;
            snz_cnt_d    = '0;
            snooze_num_d = '0;
            missed_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d      = ST_RINGING;
                        ring_cnt_d   = RING_LOAD;
                        snooze_num_d = '0;
                        missed_d     = 1'b0;
                    end
                end
                ST_RINGING: begin
                    // A snooze at the limit falls through to the countdown.
                    if (dismiss) begin
                        state_d      = ST_IDLE;
                        snooze_num_d = '0;
                    end else if (snooze && (snooze_num_q < SNOOZE_MAX)) begin
                        state_d      = ST_SNOOZE;
                        snz_cnt_d    = SNOOZE_LOAD;
                        snooze_num_d = snooze_sat_inc(snooze_num_q);
                    end else if (ring_cnt_q == '0) begin
                        state_d  = ST_IDLE;
                        missed_d = 1'b1;
                    end else begin
                        ring_cnt_d = ring_cnt_q - 7'd1;
                    end
                end
                ST_SNOOZE: begin
                    if (dismiss) begin
                        state_d      = ST_IDLE;
                        snooze_num_d = '0;
                    end else if (snz_cnt_q == '0) begin
                        state_d    = ST_RINGING;
                        ring_cnt_d = RING_LOAD;
                    end else begin
                        snz_cnt_d = snz_cnt_q - 10'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Pulse) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            match_q      <= 1'b0;
            ring_cnt_q   <= '0;
            snz_cnt_q    <= '0;
            snooze_num_q <= '0;
            missed_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            match_q      <= match;
            ring_cnt_q   <= ring_cnt_d;
            snz_cnt_q    <= snz_cnt_d;
            snooze_num_q <= snooze_num_d;
            missed_q     <= missed_d;
        end
    end

    // Outputs decode registered state only.
    assign buzz       = (state_q == ST_RINGING);
    assign snoozing   = (state_q == ST_SNOOZE);
    assign missed     = missed_q;
    assign snooze_num = snooze_num_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alarm_sequencer
//
// Directed bench for alarm_sequencer with RING_SECS=4, SNOOZE_SECS=3,
// MAX_SNOOZE=2. Inputs change 1 time unit after a rising edge and outputs are
// sampled at that same point, so each tick() shows the result of one edge.
// -----------------------------------------------------------------------------
module tb_alarm_sequencer;

    logic       Pulse = 1'b0;
    logic       Reset, alarmOn, match, snooze, dismiss;
    logic       buzz, snoozing, missed;
    logic [2:0] snooze_num;

    int pass_cnt  = 0;
    int check_cnt = 0;

    alarm_sequencer #(
        .RING_SECS  (4),
        .SNOOZE_SECS(3),
        .MAX_SNOOZE (2)
    ) dut (
        .Pulse     (Pulse),
        .Reset     (Reset),
        .alarmOn   (alarmOn),
        .match     (match),
        .snooze    (snooze),
        .dismiss   (dismiss),
        .buzz      (buzz),
        .snoozing  (snoozing),
        .missed    (missed),
        .snooze_num(snooze_num)
    );

    always #5 Pulse = ~Pulse;

    task automatic tick();
        @(posedge Pulse);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; alarmOn = 1'b0; match = 1'b0; snooze = 1'b0; dismiss = 1'b0;
        tick(); tick();
        check_cnt++; if (buzz !== 1'b0) $display("FAIL reset_buzz got %b exp 0", buzz); else pass_cnt++;
        check_cnt++; if (snoozing !== 1'b0) $display("FAIL reset_snoozing got %b exp 0", snoozing); else pass_cnt++;
        check_cnt++; if (missed !== 1'b0) $display("FAIL reset_missed got %b exp 0", missed); else pass_cnt++;
        check_cnt++; if (snooze_num !== 3'd0) $display("FAIL reset_snooze_num got %0d exp 0", snooze_num); else pass_cnt++;
        Reset = 1'b0; alarmOn = 1'b1;
        tick();
    endtask

    task automatic test_timeout();
        match = 1'b1;
        tick();   // rise sampled: ring cycle 1
        check_cnt++; if (buzz !== 1'b1) $display("FAIL timeout_start got buzz=%b exp 1", buzz); else pass_cnt++;
        for (int i = 2; i <= 4; i++) begin
            tick();
            check_cnt++; if (buzz !== 1'b1) $display("FAIL timeout_ring%0d got buzz=%b exp 1", i, buzz); else pass_cnt++;
        end
        tick();
        check_cnt++; if (buzz !== 1'b0) $display("FAIL timeout_end got buzz=%b exp 0", buzz); else pass_cnt++;
        check_cnt++; if (missed !== 1'b1) $display("FAIL timeout_missed got %b exp 1", missed); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_cnt++; if (buzz !== 1'b0) $display("FAIL timeout_retrigger%0d got buzz=%b exp 0", i, buzz); else pass_cnt++;
        end
        check_cnt++; if (missed !== 1'b1) $display("FAIL timeout_missed_sticky got %b exp 1", missed); else pass_cnt++;
        match = 1'b0;
        tick();
    endtask

    task automatic test_dismiss_match_high();
        match = 1'b1;
        tick();
        check_cnt++; if (buzz !== 1'b1) $display("FAIL dm_start got buzz=%b exp 1", buzz); else pass_cnt++;
        check_cnt++; if (missed !== 1'b0) $display("FAIL dm_missed_clear got %b exp 0", missed); else pass_cnt++;
        snooze = 1'b1;
        tick();
        snooze = 1'b0;
        check_cnt++; if (snoozing !== 1'b1 || snooze_num !== 3'd1)
            $display("FAIL dm_snooze got snoozing=%b num=%0d exp 1/1", snoozing, snooze_num); else pass_cnt++;
        dismiss = 1'b1;
        tick();
        dismiss = 1'b0;
        check_cnt++; if (buzz !== 1'b0 || snoozing !== 1'b0 || snooze_num !== 3'd0)
            $display("FAIL dm_dismiss got buzz=%b snoozing=%b num=%0d exp 0/0/0", buzz, snoozing, snooze_num); else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_cnt++; if (buzz !== 1'b0 || snooze_num !== 3'd0)
                $display("FAIL dm_quiet%0d got buzz=%b num=%0d exp 0/0", i, buzz, snooze_num); else pass_cnt++;
        end
        match = 1'b0;
        tick();
        match = 1'b1;
        tick();
        check_cnt++; if (buzz !== 1'b1) $display("FAIL dm_reraise got buzz=%b exp 1", buzz); else pass_cnt++;
        dismiss = 1'b1; match = 1'b0;
        tick();
        dismiss = 1'b0;
        tick();
    endtask

    task automatic test_snooze_rering();
        match = 1'b1;
        tick();
        tick();
        snooze = 1'b1;
        tick();   // edge M
        snooze = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            check_cnt++; if (buzz !== 1'b0 || snoozing !== 1'b1)
                $display("FAIL snz_interval%0d got buzz=%b snoozing=%b exp 0/1", i, buzz, snoozing); else pass_cnt++;
            tick();
        end
        check_cnt++; if (buzz !== 1'b1 || snoozing !== 1'b0)
            $display("FAIL snz_rering got buzz=%b snoozing=%b exp 1/0", buzz, snoozing); else pass_cnt++;
        check_cnt++; if (snooze_num !== 3'd1) $display("FAIL snz_num got %0d exp 1", snooze_num); else pass_cnt++;
        dismiss = 1'b1; match = 1'b0;
        tick();
        dismiss = 1'b0;
        tick();
    endtask

    task automatic test_snooze_limit();
        match = 1'b1;
        tick();
        for (int s = 1; s <= 2; s++) begin
            snooze = 1'b1;
            tick();
            snooze = 1'b0;
            check_cnt++; if (snoozing !== 1'b1 || snooze_num !== 3'(s))
                $display("FAIL lim_snooze%0d got snoozing=%b num=%0d exp 1/%0d", s, snoozing, snooze_num, s); else pass_cnt++;
            tick(); tick(); tick();
        end
        check_cnt++; if (buzz !== 1'b1) $display("FAIL lim_third_ring got buzz=%b exp 1", buzz); else pass_cnt++;
        snooze = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            tick();
            check_cnt++; if (buzz !== 1'b1 || snoozing !== 1'b0 || snooze_num !== 3'd2)
                $display("FAIL lim_ring%0d got buzz=%b snoozing=%b num=%0d exp 1/0/2", i, buzz, snoozing, snooze_num); else pass_cnt++;
        end
        tick();
        check_cnt++; if (buzz !== 1'b0 || missed !== 1'b1 || snooze_num !== 3'd2)
            $display("FAIL lim_timeout got buzz=%b missed=%b num=%0d exp 0/1/2", buzz, missed, snooze_num); else pass_cnt++;
        snooze = 1'b0; match = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous();
        match = 1'b1;
        tick();
        snooze = 1'b1; dismiss = 1'b1;
        tick();
        snooze = 1'b0; dismiss = 1'b0;
        check_cnt++; if (buzz !== 1'b0 || snoozing !== 1'b0 || snooze_num !== 3'd0)
            $display("FAIL simul got buzz=%b snoozing=%b num=%0d exp 0/0/0", buzz, snoozing, snooze_num); else pass_cnt++;
        // dismiss inside a snooze interval
        match = 1'b0;
        tick();
        match = 1'b1;
        tick();
        snooze = 1'b1;
        tick();
        snooze = 1'b0; dismiss = 1'b1;
        tick();
        dismiss = 1'b0;
        check_cnt++; if (snoozing !== 1'b0 || buzz !== 1'b0 || snooze_num !== 3'd0)
            $display("FAIL snz_dismiss got buzz=%b snoozing=%b num=%0d exp 0/0/0", buzz, snoozing, snooze_num); else pass_cnt++;
        match = 1'b0;
        tick();
    endtask

    task automatic test_override();
        match = 1'b1;
        tick();
        snooze = 1'b1;
        tick();
        snooze = 1'b0;
        check_cnt++; if (snoozing !== 1'b1) $display("FAIL ovr_pre got snoozing=%b exp 1", snoozing); else pass_cnt++;
        alarmOn = 1'b0;
        tick();
        check_cnt++; if (buzz !== 1'b0 || snoozing !== 1'b0 || missed !== 1'b0 || snooze_num !== 3'd0)
            $display("FAIL ovr_clear got buzz=%b snoozing=%b missed=%b num=%0d exp 0/0/0/0", buzz, snoozing, missed, snooze_num); else pass_cnt++;
        match = 1'b0;
        tick();
        match = 1'b1;   // rise with alarmOn low
        tick();
        check_cnt++; if (buzz !== 1'b0) $display("FAIL ovr_rise_off got buzz=%b exp 0", buzz); else pass_cnt++;
        alarmOn = 1'b1;
        tick();
        check_cnt++; if (buzz !== 1'b0) $display("FAIL ovr_no_late_rise got buzz=%b exp 0", buzz); else pass_cnt++;
        match = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_ring();
        match = 1'b1;
        tick();
        tick();
        check_cnt++; if (buzz !== 1'b1) $display("FAIL rst_pre got buzz=%b exp 1", buzz); else pass_cnt++;
        Reset = 1'b1;
        tick();
        check_cnt++; if (buzz !== 1'b0 || snoozing !== 1'b0 || missed !== 1'b0 || snooze_num !== 3'd0)
            $display("FAIL rst_during got buzz=%b snoozing=%b missed=%b num=%0d exp 0/0/0/0", buzz, snoozing, missed, snooze_num); else pass_cnt++;
        tick();
        check_cnt++; if (buzz !== 1'b0) $display("FAIL rst_hold got buzz=%b exp 0", buzz); else pass_cnt++;
        Reset = 1'b0;
        tick();
        check_cnt++; if (buzz !== 1'b1) $display("FAIL rst_release got buzz=%b exp 1", buzz); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_dismiss_match_high();
        test_snooze_rering();
        test_snooze_limit();
        test_simultaneous();
        test_override();
        test_reset_mid_ring();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
